ama_riscv_csr_cnt_bank: RTL

// Parametrised machine counter bank: mcycle, minstret, and NUM_HPM event counters (mhpmcounter3..).

---
 rtl/ama_riscv_csr_cnt_bank.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_csr_cnt_bank.sv
// ----------------------------------------------------------------------------
// ama_riscv_csr_cnt_bank
//
// Machine counter bank: mcycle, minstret, NUM_HPM event counters
// (mhpmcounter3..) and mcountinhibit. All of them support Zicsr
// assign/set/clear writes. Each counter is CNT_W bits wide and is exposed
// as a low word (cnt[31:0]) and a zero-extended high word (cnt[CNT_W-1:32]).
// The C-range user aliases are read-only mirrors of the same counters.
//
// Ports
//   i_clk          core clock
//   i_rst          synchronous reset, active-high
//   i_csr_en       CSR access valid this cycle
//   i_csr_we       access carries a write (0 = read-only)
//   i_csr_op       NONE / ASSIGN / SET_BITS / CLR_BITS
//   i_csr_addr     12-bit CSR address
//   i_csr_wdata    resolved write operand
//   i_retire       one instruction retired this cycle
//   i_hpm_evt      per-counter event pulse, one increment per cycle
//   o_csr_rdata    registered read data (value before this cycle's update)
//   o_csr_rvalid   one-cycle pulse, one cycle after an access
//   o_csr_illegal  unmapped address, or write to a read-only mirror
// ----------------------------------------------------------------------------
module ama_riscv_csr_cnt_bank #(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_csr_en,
    input  logic                                i_csr_we,
    input  logic [1:0]                          i_csr_op,
    input  logic [11:0]                         i_csr_addr,
    input  logic [31:0]                         i_csr_wdata,
    input  logic                                i_retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] i_hpm_evt,
    output logic [31:0]                         o_csr_rdata,
    output logic                                o_csr_rvalid,
    output logic                                o_csr_illegal
);

    typedef enum logic [1:0] {
        CSR_OP_NONE   = 2'd0,
        CSR_OP_ASSIGN = 2'd1,
        CSR_OP_SET    = 2'd2,
        CSR_OP_CLR    = 2'd3
    } csr_op_t;

    // Storage is sized for at least one event counter so NUM_HPM = 0 still
    // elaborates; the spare entry is never addressed or incremented.
    localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int HI_W  = CNT_W - 32;

    // Implemented mcountinhibit bits: CY (0), IR (2) and HPM3.. upward.
    localparam logic [63:0] HPM_BITS = ((64'h1 << NUM_HPM) - 64'h1) << 3;
    localparam logic [31:0] INH_MASK = 32'h5 | HPM_BITS[31:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;
    logic [CNT_W-1:0] r_hpm [HPM_N];
    logic [31:0]      r_inhibit;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    csr_op_t          w_op;
    logic             w_access;
    logic             w_hi;
    logic [4:0]       w_idx;
    logic             w_range_m;
    logic             w_range_u;
    logic             w_idx_ok;
    logic             w_is_inh;
    logic             w_mapped;
    logic             w_mirror;
    logic             w_illegal;
    logic             w_wr;
    logic             w_wr_cyc;
    logic             w_wr_ret;
    logic             w_wr_inh;
    logic [HPM_N-1:0] w_wr_hpm;
    logic [CNT_W-1:0] w_sel_cnt;
    logic [31:0]      w_old;
    logic [31:0]      w_new;

    assign w_op      = csr_op_t'(i_csr_op);
    assign w_access  = i_csr_en && (w_op != CSR_OP_NONE);
    assign w_hi      = i_csr_addr[7];
    assign w_idx     = i_csr_addr[4:0];
    assign w_range_m = (i_csr_addr[11:8] == 4'hB) && (i_csr_addr[6:5] == 2'b00);
    assign w_range_u = (i_csr_addr[11:8] == 4'hC) && (i_csr_addr[6:5] == 2'b00);
    // Index 1 (time) is not held here, so it decodes as unmapped.
    assign w_idx_ok  = (w_idx == 5'd0) || (w_idx == 5'd2) ||
                       ((w_idx >= 5'd3) && (int'(w_idx) < 3 + NUM_HPM));
    assign w_is_inh  = (i_csr_addr == 12'h320);
    assign w_mapped  = ((w_range_m || w_range_u) && w_idx_ok) || w_is_inh;
    assign w_mirror  = w_range_u && w_idx_ok;
    assign w_illegal = w_access && (!w_mapped || (w_mirror && i_csr_we));
    assign w_wr      = w_access && i_csr_we && w_mapped && !w_mirror;
    assign w_wr_cyc  = w_wr && w_range_m && (w_idx == 5'd0);
    assign w_wr_ret  = w_wr && w_range_m && (w_idx == 5'd2);
    assign w_wr_inh  = w_wr && w_is_inh;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // unmatched index values cannot leave a latch behind.
        w_sel_cnt = '0;
        w_wr_hpm  = '0;
        if (w_idx == 5'd0) begin
            w_sel_cnt = r_mcycle;
        end else if (w_idx == 5'd2) begin
            w_sel_cnt = r_minstret;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (int'(w_idx) == 3 + i) begin
                w_sel_cnt   = r_hpm[i];
                w_wr_hpm[i] = w_wr && w_range_m;
            end
        end
    end

    always_comb begin
        w_old = '0;
        if (w_is_inh) begin
            w_old = r_inhibit;
        end else if ((w_range_m || w_range_u) && w_idx_ok) begin
            w_old = w_hi ? 32'(w_sel_cnt[CNT_W-1:32]) : w_sel_cnt[31:0];
        end
    end

    always_comb begin
        w_new = i_csr_wdata;
        case (w_op)
            CSR_OP_SET: w_new = w_old | i_csr_wdata;
            CSR_OP_CLR: w_new = w_old & ~i_csr_wdata;
            default:    w_new = i_csr_wdata;
        endcase
    end

    // A write to either half replaces that half and drops this cycle's
    // increment; the other half is kept as it was.
    function automatic logic [CNT_W-1:0] f_cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             wr,
        input logic             hi,
        input logic [31:0]      wval,
        input logic             inc
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt + CNT_W'(inc);
        if (wr) begin
            if (hi) begin
                nxt = {wval[HI_W-1:0], cnt[31:0]};
            end else begin
                nxt = {cnt[CNT_W-1:32], wval};
            end
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the counter array is cleared by reset like any other
            // architectural state; software expects counters to start at 0.
            r_mcycle      <= '0;
            r_minstret    <= '0;
            for (int i = 0; i < HPM_N; i++) begin
                r_hpm[i] <= '0;
            end
            r_inhibit     <= '0;
            o_csr_rdata   <= '0;
            o_csr_rvalid  <= 1'b0;
            o_csr_illegal <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every counter and the
            // read data see the pre-edge inhibit and pre-edge counter values.
            r_mcycle   <= f_cnt_next(r_mcycle, w_wr_cyc, w_hi, w_new,
                                     !r_inhibit[0]);
            r_minstret <= f_cnt_next(r_minstret, w_wr_ret, w_hi, w_new,
                                     i_retire && !r_inhibit[2]);
            for (int i = 0; i < NUM_HPM; i++) begin
                r_hpm[i] <= f_cnt_next(r_hpm[i], w_wr_hpm[i], w_hi, w_new,
                                       i_hpm_evt[i] && !r_inhibit[3+i]);
            end
            if (w_wr_inh) begin
                r_inhibit <= w_new & INH_MASK;
            end
            o_csr_rdata   <= w_access ? w_old : '0;
            o_csr_rvalid  <= w_access;
            o_csr_illegal <= w_illegal;
        end
    end

endmodule
